// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges the non-stalling pipeline writeback with a
// back-pressured multiply/divide result stream, and tracks registers still owed by MD.
module rf_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WB_VALID,
    input  logic [4:0]               WB_ADDR,
    input  logic [31:0]              WB_DATA,
    input  logic                     MD_VALID,
    input  logic [4:0]               MD_ADDR,
    input  logic [31:0]              MD_DATA,
    output logic                     MD_READY,
    input  logic                     ISSUE_VALID,
    input  logic [4:0]               ISSUE_ADDR,
    input  logic [4:0]               Q_ADDR_1,
    input  logic [4:0]               Q_ADDR_2,
    output logic                     Q_BUSY_1,
    output logic                     Q_BUSY_2,
    output logic                     WE,
    output logic [4:0]               WR_ADDR_3,
    output logic [31:0]              W_DATA,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    wr_req_t          mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [31:0]      pending, pending_nxt;
    wr_req_t          src;
    logic             src_vld, md_src;
    logic             md_fire, nonempty, push, pop;

    assign MD_READY = !RESET && (FIFO_COUNT != FULL);
    assign md_fire  = MD_VALID && MD_READY;
    assign nonempty = (FIFO_COUNT != '0);
    assign pop      = !WB_VALID && nonempty;
    // Only the bypass case (idle writeback, empty FIFO) skips storage.
    assign push     = md_fire && (WB_VALID || nonempty);

    always_comb begin
        src     = '{addr: WB_ADDR, data: WB_DATA};
        src_vld = 1'b0;
        md_src  = 1'b0;
        if (WB_VALID) begin
            src_vld = 1'b1;
        end else if (nonempty) begin
            src     = mem[rd_ptr];
            src_vld = 1'b1;
            md_src  = 1'b1;
        end else if (md_fire) begin
            src     = '{addr: MD_ADDR, data: MD_DATA};
            src_vld = 1'b1;
            md_src  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{addr: MD_ADDR, data: MD_DATA};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            FIFO_COUNT <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   FIFO_COUNT <= FIFO_COUNT + 1'b1;
                2'b01:   FIFO_COUNT <= FIFO_COUNT - 1'b1;
                default: FIFO_COUNT <= FIFO_COUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            WE        <= 1'b0;
            WR_ADDR_3 <= '0;
            W_DATA    <= '0;
        end else if (src_vld) begin
            WE        <= (src.addr != 5'd0);
            WR_ADDR_3 <= src.addr;
            W_DATA    <= src.data;
        end else begin
            WE        <= 1'b0;
        end
    end

    // Clear before set so a same-cycle reissue keeps the register busy.
    always_comb begin
        pending_nxt = pending;
        if (md_src) pending_nxt[src.addr] = 1'b0;
        if (ISSUE_VALID && ISSUE_ADDR != 5'd0) pending_nxt[ISSUE_ADDR] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) pending <= '0;
        else       pending <= pending_nxt;
    end

    assign Q_BUSY_1 = pending[Q_ADDR_1];
    assign Q_BUSY_2 = pending[Q_ADDR_2];
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_rf_write_arbiter;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WB_VALID, MD_VALID, ISSUE_VALID;
    logic [4:0]  WB_ADDR, MD_ADDR, ISSUE_ADDR, Q_ADDR_1, Q_ADDR_2;
    logic [31:0] WB_DATA, MD_DATA;
    logic        MD_READY, Q_BUSY_1, Q_BUSY_2, WE;
    logic [4:0]  WR_ADDR_3;
    logic [31:0] W_DATA;
    logic [2:0]  FIFO_COUNT;

    rf_write_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .MD_VALID(MD_VALID), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR),
        .Q_ADDR_1(Q_ADDR_1), .Q_ADDR_2(Q_ADDR_2), .Q_BUSY_1(Q_BUSY_1), .Q_BUSY_2(Q_BUSY_2),
        .WE(WE), .WR_ADDR_3(WR_ADDR_3), .W_DATA(W_DATA), .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the FIFO is a queue of {addr,data}, pending is a bit array.
    logic [36:0] q[$];
    bit          pend [32];
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    bit          model_on = 0;

    always @(posedge CLK) begin
        bit          fire, bypass, md_wr;
        logic [36:0] e;
        logic [4:0]  a;
        logic [31:0] d;
        if (RESET) begin
            model_on = 1;
            exp_we   = 0;
            exp_addr = '0;
            exp_data = '0;
            q.delete();
            foreach (pend[i]) pend[i] = 0;
        end else begin
            fire   = MD_VALID && (q.size() != DEPTH);
            bypass = 0;
            md_wr  = 0;
            a = '0;
            d = '0;
            if (WB_VALID) begin
                a = WB_ADDR; d = WB_DATA;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                a = e[36:32]; d = e[31:0]; md_wr = 1;
            end else if (fire) begin
                a = MD_ADDR; d = MD_DATA; md_wr = 1; bypass = 1;
            end
            if (WB_VALID || md_wr) begin
                exp_we = (a != 0); exp_addr = a; exp_data = d;
            end else begin
                exp_we = 0;
            end
            if (fire && !bypass) q.push_back({MD_ADDR, MD_DATA});
            if (md_wr) pend[a] = 0;
            if (ISSUE_VALID && ISSUE_ADDR != 0) pend[ISSUE_ADDR] = 1;
        end
    end

    always @(negedge CLK) begin
        if (model_on) begin
            chk("m_we", WE, exp_we);
            if (exp_we) begin
                chk("m_addr", WR_ADDR_3, exp_addr);
                chk("m_data", W_DATA, exp_data);
            end
            chk("m_count", FIFO_COUNT, q.size());
            chk("m_ready", MD_READY, !RESET && q.size() != DEPTH);
            chk("m_busy1", Q_BUSY_1, pend[Q_ADDR_1]);
            chk("m_busy2", Q_BUSY_2, pend[Q_ADDR_2]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WB_VALID = 0; MD_VALID = 0; ISSUE_VALID = 0;
    endtask

    initial begin
        int  k;
        bit  hs;
        RESET = 1;
        WB_VALID = 0; WB_ADDR = 0; WB_DATA = 0;
        MD_VALID = 1; MD_ADDR = 5; MD_DATA = 32'h55;
        ISSUE_VALID = 1; ISSUE_ADDR = 5;
        Q_ADDR_1 = 5; Q_ADDR_2 = 0;

        // Reset with MD and issue requests present
        tick(); tick();
        chk("rst_we", WE, 0);
        chk("rst_ready", MD_READY, 0);
        chk("rst_count", FIFO_COUNT, 0);
        idle();
        RESET = 0;
        #1;
        chk("rst_busy5", Q_BUSY_1, 0);
        chk("rst_ready_rel", MD_READY, 1);

        // Writeback path
        WB_VALID = 1; WB_ADDR = 7; WB_DATA = 32'hDEADBEEF;
        tick();
        chk("wb_we", WE, 1);
        chk("wb_addr", WR_ADDR_3, 7);
        chk("wb_data", W_DATA, 32'hDEADBEEF);
        WB_ADDR = 0;
        tick();
        chk("wb_r0_we", WE, 0);
        idle();

        // Issue then bypass
        ISSUE_VALID = 1; ISSUE_ADDR = 9; Q_ADDR_1 = 9;
        tick();
        ISSUE_VALID = 0;
        chk("iss_busy9", Q_BUSY_1, 1);
        MD_VALID = 1; MD_ADDR = 9; MD_DATA = 32'h12345678;
        tick();
        MD_VALID = 0;
        chk("byp_we", WE, 1);
        chk("byp_addr", WR_ADDR_3, 9);
        chk("byp_data", W_DATA, 32'h12345678);
        chk("byp_busy9", Q_BUSY_1, 0);
        chk("byp_count", FIFO_COUNT, 0);

        // Fill under sustained writeback
        WB_VALID = 1; WB_ADDR = 20; WB_DATA = 32'hFEED;
        k = 1;
        for (int c = 0; c < 6; c++) begin
            MD_VALID = (k <= 6); MD_ADDR = 5'(k); MD_DATA = 32'hA000_0000 | k;
            hs = MD_VALID && MD_READY;
            tick();
            if (hs) k++;
        end
        chk("fill_count", FIFO_COUNT, 4);
        chk("fill_ready", MD_READY, 0);
        chk("fill_accepted", k, 5);
        WB_VALID = 0;
        for (int j = 1; j <= 6; j++) begin
            MD_VALID = (k <= 6); MD_ADDR = 5'(k); MD_DATA = 32'hA000_0000 | k;
            hs = MD_VALID && MD_READY;
            tick();
            if (hs) k++;
            chk("drain_we", WE, 1);
            chk("drain_addr", WR_ADDR_3, j);
            chk("drain_data", W_DATA, 32'hA000_0000 | j);
        end
        MD_VALID = 0;
        chk("drain_count", FIFO_COUNT, 0);
        chk("drain_all", k, 7);

        // Set wins over clear on the same register
        ISSUE_VALID = 1; ISSUE_ADDR = 3; Q_ADDR_2 = 3;
        tick();
        MD_VALID = 1; MD_ADDR = 3; MD_DATA = 32'h33;
        tick();
        idle();
        chk("sim_we", WE, 1);
        chk("sim_addr", WR_ADDR_3, 3);
        chk("sim_busy3", Q_BUSY_2, 1);

        // Writeback beats a ready FIFO head
        WB_VALID = 1; WB_ADDR = 12; WB_DATA = 32'hC;
        MD_VALID = 1; MD_ADDR = 11; MD_DATA = 32'hB;
        tick();
        MD_VALID = 0;
        chk("pri_addr12", WR_ADDR_3, 12);
        chk("pri_count1", FIFO_COUNT, 1);
        WB_ADDR = 13; WB_DATA = 32'hD;
        tick();
        WB_VALID = 0;
        chk("pri_addr13", WR_ADDR_3, 13);
        chk("pri_count_held", FIFO_COUNT, 1);
        tick();
        chk("pri_head_we", WE, 1);
        chk("pri_head_addr", WR_ADDR_3, 11);
        chk("pri_head_data", W_DATA, 32'hB);
        chk("pri_count0", FIFO_COUNT, 0);

        // Reset mid-operation
        WB_VALID = 1; WB_ADDR = 25; WB_DATA = 32'h25;
        for (int i = 0; i < 3; i++) begin
            MD_VALID = 1; MD_ADDR = 5'(20 + i); MD_DATA = 32'h200 + i;
            ISSUE_VALID = 1; ISSUE_ADDR = 5'(20 + i);
            tick();
        end
        idle();
        Q_ADDR_1 = 20;
        #1;
        chk("mid_count3", FIFO_COUNT, 3);
        chk("mid_busy20", Q_BUSY_1, 1);
        RESET = 1;
        tick();
        chk("mid_rst_count", FIFO_COUNT, 0);
        chk("mid_rst_we", WE, 0);
        RESET = 0;
        #1;
        chk("mid_busy20_clr", Q_BUSY_1, 0);
        chk("mid_busy3_clr", Q_BUSY_2, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", WE, 0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int wb_pct;
            wb_pct = (c / 500) % 2 ? 80 : 30;
            RESET       = ($urandom_range(0, 199) == 0);
            WB_VALID    = ($urandom_range(0, 99) < wb_pct);
            WB_ADDR     = 5'($urandom_range(0, 31));
            WB_DATA     = $urandom;
            MD_VALID    = ($urandom_range(0, 99) < 60);
            MD_ADDR     = 5'($urandom_range(0, 31));
            MD_DATA     = $urandom;
            ISSUE_VALID = ($urandom_range(0, 99) < 40);
            ISSUE_ADDR  = 5'($urandom_range(0, 31));
            Q_ADDR_1    = 5'($urandom_range(0, 31));
            Q_ADDR_2    = 5'($urandom_range(0, 31));
            tick();
        end
        RESET = 0;
        idle();
        tick();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
